micro_sequencer: RTL and testbench

//  Microprogram sequencer for the multi-cycle processor: holds the micro-PC and selects
//  the next micro-ROM address each cycle (sequential, dispatch, fetch, timed wait).

---
 rtl/micro_sequencer_pkg.sv | 21 ++
 rtl/micro_wait_counter.sv | 29 ++
 rtl/micro_sequencer.sv | 113 +++++++++++
 tb/tb_micro_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the microprogram sequencer: next-address controls,
// sequencer states and default micro-ROM entry points.
package micro_sequencer_pkg;

  typedef enum logic [1:0] {
    ACTL_SEQ      = 2'b00,
    ACTL_DISPATCH = 2'b01,
    ACTL_FETCH    = 2'b10,
    ACTL_WAIT     = 2'b11
  } addr_ctl_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_TRAP = 2'b10
  } seq_state_e;

  localparam logic [7:0] DEF_FETCH_ADDR = 8'h00;
  localparam logic [7:0] DEF_TRAP_ADDR  = 8'hFF;

endpackage

// File: rtl/micro_wait_counter.sv
// Down-counter timing a WAIT micro-op; o_last flags the edge that ends the wait.
module micro_wait_counter #(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = $clog2(WAIT_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_last
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register and next-address selection (SEQ/DISPATCH/FETCH/WAIT)
// with a timed wait state and a sticky illegal-opcode trap.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int               UPC_W       = 8,
  parameter logic [UPC_W-1:0] FETCH_ADDR  = DEF_FETCH_ADDR,
  parameter logic [UPC_W-1:0] TRAP_ADDR   = DEF_TRAP_ADDR,
  parameter int               WAIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_addr_ctl,
  input  logic [UPC_W-1:0] i_state,
  input  logic             i_dispatch_valid,
  input  logic             i_stall,
  output logic [UPC_W-1:0] o_upc,
  output logic             o_busy,
  output logic             o_illegal,
  output logic             o_instr_done
);

  seq_state_e       r_state, w_state_next;
  logic [UPC_W-1:0] r_upc, w_upc_next;
  logic             r_illegal, w_illegal_next;
  logic             r_instr_done, w_instr_done_next;
  logic             r_busy;
  logic             w_cnt_load, w_cnt_en, w_cnt_last;

  micro_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_last (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_upc        <= FETCH_ADDR;
      r_illegal    <= 1'b0;
      r_instr_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_upc        <= w_upc_next;
      r_illegal    <= w_illegal_next;
      r_instr_done <= w_instr_done_next;
      r_busy       <= (w_state_next == ST_WAIT);
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_upc_next        = r_upc;
    w_illegal_next    = r_illegal;
    w_instr_done_next = 1'b0;
    w_cnt_load        = 1'b0;
    w_cnt_en          = 1'b0;
    case (r_state)
      ST_TRAP: begin
        w_upc_next     = TRAP_ADDR;
        w_illegal_next = 1'b1;
      end
      ST_WAIT: begin
        if (!i_stall) begin
          w_cnt_en = 1'b1;
          if (w_cnt_last) begin
            w_upc_next   = r_upc + 1'b1;
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!i_stall) begin
          case (addr_ctl_e'(i_addr_ctl))
            ACTL_SEQ: w_upc_next = r_upc + 1'b1;
            ACTL_DISPATCH: begin
              // i_state is only looked at when valid, so an X there never reaches o_upc
              if (i_dispatch_valid) begin
                w_upc_next = i_state;
              end else begin
                w_upc_next     = TRAP_ADDR;
                w_illegal_next = 1'b1;
                w_state_next   = ST_TRAP;
              end
            end
            ACTL_FETCH: begin
              w_upc_next        = FETCH_ADDR;
              w_instr_done_next = 1'b1;
            end
            ACTL_WAIT: begin
              w_cnt_load = 1'b1;
              if (WAIT_CYCLES == 1) w_upc_next = r_upc + 1'b1;
              else                  w_state_next = ST_WAIT;
            end
            default: w_upc_next = r_upc;
          endcase
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign o_upc        = r_upc;
  assign o_busy       = r_busy;
  assign o_illegal    = r_illegal;
  assign o_instr_done = r_instr_done;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_micro_sequencer;

  localparam int         WAIT_CYCLES = 4;
  localparam logic [7:0] FETCH_A     = 8'h00;
  localparam logic [7:0] TRAP_A      = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] i_addr_ctl = 2'b00;
  logic [7:0] i_state = 8'h00;
  logic       i_dispatch_valid = 1'b1;
  logic       i_stall = 1'b0;
  logic [7:0] o_upc;
  logic       o_busy, o_illegal, o_instr_done;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0 = running, 1 = waiting, 2 = trapped
  logic [7:0] m_upc = FETCH_A;
  int         m_mode = 0;
  int         m_left = 0;
  logic       m_busy = 1'b0, m_ill = 1'b0, m_done = 1'b0;

  micro_sequencer #(
    .UPC_W(8), .FETCH_ADDR(FETCH_A), .TRAP_ADDR(TRAP_A), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .i_addr_ctl(i_addr_ctl), .i_state(i_state),
    .i_dispatch_valid(i_dispatch_valid), .i_stall(i_stall), .o_upc(o_upc),
    .o_busy(o_busy), .o_illegal(o_illegal), .o_instr_done(o_instr_done)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input logic rst, input logic [1:0] ctl,
                                     input logic [7:0] st, input logic v, input logic stall);
    if (rst) begin
      m_upc = FETCH_A; m_mode = 0; m_left = 0; m_busy = 0; m_ill = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_mode == 2 || stall) return;
    if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_upc = m_upc + 8'd1; m_mode = 0; m_busy = 0;
      end
      return;
    end
    case (ctl)
      2'b00: m_upc = m_upc + 8'd1;
      2'b01: if (v) m_upc = st;
             else begin m_upc = TRAP_A; m_ill = 1; m_mode = 2; end
      2'b10: begin m_upc = FETCH_A; m_done = 1; end
      default: if (WAIT_CYCLES == 1) m_upc = m_upc + 8'd1;
               else begin m_mode = 1; m_left = WAIT_CYCLES - 1; m_busy = 1; end
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic step(input logic rst, input logic [1:0] ctl, input logic [7:0] st,
                      input logic v, input logic stall);
    reset = rst; i_addr_ctl = ctl; i_state = st; i_dispatch_valid = v; i_stall = stall;
    @(posedge clk);
    model_edge(rst, ctl, st, v, stall);
    #1;
    $display("t=%0t rst=%0b ctl=%0d st=%02h v=%0b stall=%0b -> upc=%02h busy=%0b ill=%0b done=%0b",
             $time, rst, ctl, st, v, stall, o_upc, o_busy, o_illegal, o_instr_done);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    n_checks++;
    if (o_upc !== 8'h00 || o_busy !== 0 || o_illegal !== 0 || o_instr_done !== 0) begin
      n_errors++;
      $display("FAIL reset_initial: upc=%02h busy=%0b ill=%0b done=%0b, want 00/0/0/0",
               o_upc, o_busy, o_illegal, o_instr_done);
    end
    step(0, 2'b11, 0, 1, 0);
    step(0, 2'b00, 0, 1, 0);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_errors++; $display("FAIL reset_pre_wait_busy: busy=%0b want 1", o_busy);
    end
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    n_checks++;
    if (o_upc !== 8'h00 || o_busy !== 0 || o_illegal !== 0 || o_instr_done !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_wait: upc=%02h busy=%0b ill=%0b done=%0b, want 00/0/0/0",
               o_upc, o_busy, o_illegal, o_instr_done);
    end
  endtask

  task automatic test_seq_dispatch;
    logic [7:0] exp_tab [4];
    exp_tab = '{8'h01, 8'h02, 8'h03, 8'h10};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) step(0, 2'b00, 8'h00, 1, 0);
      else       step(0, 2'b01, 8'h10, 1, 0);
      n_checks++;
      if (o_upc !== exp_tab[k]) begin
        n_errors++; $display("FAIL seq_dispatch[%0d]: upc=%02h want %02h", k, o_upc, exp_tab[k]);
      end
    end
  endtask

  task automatic test_wait_stall;
    logic [4:0] stall_tab;
    stall_tab = 5'b00110;  // bit k = stall on step k after the WAIT issue
    step(0, 2'b11, 8'h00, 1, 0);
    n_checks++;
    if (o_upc !== 8'h10 || o_busy !== 1'b1) begin
      n_errors++; $display("FAIL wait_enter: upc=%02h busy=%0b want 10/1", o_upc, o_busy);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 2'b10, 8'h00, 1, stall_tab[k]);
      n_checks++;
      if (k < 4 && (o_upc !== 8'h10 || o_busy !== 1'b1 || o_instr_done !== 1'b0)) begin
        n_errors++;
        $display("FAIL wait_hold[%0d]: upc=%02h busy=%0b done=%0b want 10/1/0",
                 k, o_upc, o_busy, o_instr_done);
      end else if (k == 4 && (o_upc !== 8'h11 || o_busy !== 1'b0)) begin
        n_errors++; $display("FAIL wait_exit: upc=%02h busy=%0b want 11/0", o_upc, o_busy);
      end
    end
  endtask

  task automatic test_fetch;
    step(0, 2'b01, 8'h0E, 1, 0);
    step(0, 2'b10, 8'h00, 1, 0);
    n_checks++;
    if (o_upc !== 8'h00 || o_instr_done !== 1'b1) begin
      n_errors++; $display("FAIL fetch: upc=%02h done=%0b want 00/1", o_upc, o_instr_done);
    end
    step(0, 2'b00, 8'h00, 1, 0);
    n_checks++;
    if (o_upc !== 8'h01 || o_instr_done !== 1'b0) begin
      n_errors++; $display("FAIL fetch_pulse_end: upc=%02h done=%0b want 01/0", o_upc, o_instr_done);
    end
  endtask

  task automatic test_wrap;
    step(0, 2'b01, 8'hFE, 1, 0);
    step(0, 2'b00, 8'h00, 1, 0);
    n_checks++;
    if (o_upc !== 8'hFF || o_illegal !== 1'b0) begin
      n_errors++; $display("FAIL wrap_ff: upc=%02h ill=%0b want FF/0", o_upc, o_illegal);
    end
    step(0, 2'b00, 8'h00, 1, 0);
    n_checks++;
    if (o_upc !== 8'h00 || o_illegal !== 1'b0) begin
      n_errors++; $display("FAIL wrap_00: upc=%02h ill=%0b want 00/0", o_upc, o_illegal);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] ctl_tab [4];
    ctl_tab = '{2'b10, 2'b00, 2'b11, 2'b01};
    step(0, 2'b01, 8'hxx, 0, 0);
    n_checks++;
    if (o_upc !== 8'hFF || o_illegal !== 1'b1) begin
      n_errors++; $display("FAIL illegal_enter: upc=%02h ill=%0b want FF/1", o_upc, o_illegal);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, ctl_tab[k], 8'h22, 1, k[0]);
      n_checks++;
      if (o_upc !== 8'hFF || o_illegal !== 1'b1 || o_instr_done !== 1'b0 || o_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL illegal_hold[%0d]: upc=%02h ill=%0b done=%0b busy=%0b want FF/1/0/0",
                 k, o_upc, o_illegal, o_instr_done, o_busy);
      end
    end
    step(1, 0, 0, 1, 0);
    n_checks++;
    if (o_upc !== 8'h00 || o_illegal !== 1'b0) begin
      n_errors++; $display("FAIL illegal_reset: upc=%02h ill=%0b want 00/0", o_upc, o_illegal);
    end
  endtask

  task automatic test_random;
    logic       rst, v, stall;
    logic [1:0] ctl;
    logic [7:0] st;
    step(1, 0, 0, 1, 0);
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      ctl   = 2'($urandom_range(0, 3));
      st    = 8'($urandom_range(0, 255));
      v     = ($urandom_range(0, 11) != 0);
      stall = ($urandom_range(0, 4) == 0);
      step(rst, ctl, st, v, stall);
      n_checks++;
      if (o_upc !== m_upc || o_busy !== m_busy || o_illegal !== m_ill || o_instr_done !== m_done) begin
        n_errors++;
        $display("FAIL random[%0d]: upc=%02h busy=%0b ill=%0b done=%0b want %02h/%0b/%0b/%0b",
                 n, o_upc, o_busy, o_illegal, o_instr_done, m_upc, m_busy, m_ill, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_dispatch();
    test_wait_stall();
    test_fetch();
    test_wrap();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
